// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with a one-entry skid buffer, flush, stall hold and
// a saturating held-cycle counter.
module pipe_stage_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 16,
  parameter logic [CTRL_W-1:0] BUBBLE_CTRL = {CTRL_W{1'b0}},
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              stall,
  input  logic              flush,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic              main_valid, main_valid_d;
  logic [CTRL_W-1:0] main_ctrl, main_ctrl_d;
  logic [DATA_W-1:0] main_data, main_data_d;
  logic              skid_valid, skid_valid_d;
  logic [CTRL_W-1:0] skid_ctrl, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data, skid_data_d;
  logic [CNT_W-1:0]  cnt, cnt_d;

  logic in_xfer;
  logic take;
  logic main_load;

  assign in_xfer   = in_valid & ~skid_valid;
  assign take      = main_valid & out_ready & ~stall;
  assign main_load = ~main_valid | take;

  // Next-state for both entries; flush overrides every other event.
  always_comb begin
    main_valid_d = main_valid;
    main_ctrl_d  = main_ctrl;
    main_data_d  = main_data;
    skid_valid_d = skid_valid;
    skid_ctrl_d  = skid_ctrl;
    skid_data_d  = skid_data;

    if (flush) begin
      main_valid_d = 1'b0;
      main_ctrl_d  = BUBBLE_CTRL;
      main_data_d  = '0;
      skid_valid_d = 1'b0;
      skid_ctrl_d  = BUBBLE_CTRL;
      skid_data_d  = '0;
    end else begin
      if (main_load) begin
        if (skid_valid) begin
          main_valid_d = 1'b1;
          main_ctrl_d  = skid_ctrl;
          main_data_d  = skid_data;
        end else if (in_xfer) begin
          main_valid_d = 1'b1;
          main_ctrl_d  = in_ctrl;
          main_data_d  = in_data;
        end else begin
          main_valid_d = 1'b0;
          main_ctrl_d  = BUBBLE_CTRL;
          main_data_d  = '0;
        end
      end

      // Skid only captures input that main cannot absorb this cycle.
      if (skid_valid) begin
        if (main_load) begin
          if (in_xfer) begin
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
          end else begin
            skid_valid_d = 1'b0;
            skid_ctrl_d  = BUBBLE_CTRL;
            skid_data_d  = '0;
          end
        end
      end else if (in_xfer && !main_load) begin
        skid_valid_d = 1'b1;
        skid_ctrl_d  = in_ctrl;
        skid_data_d  = in_data;
      end
    end
  end

  // Held-cycle counter: counts live-but-not-taken cycles, frozen on flush.
  always_comb begin
    cnt_d = cnt;
    if (!flush && main_valid && !take && (cnt != CNT_MAX)) begin
      cnt_d = cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid <= 1'b0;
      main_ctrl  <= BUBBLE_CTRL;
      main_data  <= '0;
      skid_valid <= 1'b0;
      skid_ctrl  <= BUBBLE_CTRL;
      skid_data  <= '0;
      cnt        <= '0;
    end else begin
      main_valid <= main_valid_d;
      main_ctrl  <= main_ctrl_d;
      main_data  <= main_data_d;
      skid_valid <= skid_valid_d;
      skid_ctrl  <= skid_ctrl_d;
      skid_data  <= skid_data_d;
      cnt        <= cnt_d;
    end
  end

  assign in_ready  = ~skid_valid;
  assign out_valid = main_valid;
  assign out_ctrl  = main_valid ? main_ctrl : BUBBLE_CTRL;
  assign out_data  = main_data;
  assign stall_cnt = cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg: streaming, backpressure,
// flush, skid hand-off, async reset and counter saturation.
module tb_pipe_stage_reg;

  localparam logic [15:0] BUB = 16'h00F0;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_ctrl;
  logic [31:0] in_data;
  logic        stall;
  logic        flush;
  logic        out_ready;
  logic        out_valid;
  logic [15:0] out_ctrl;
  logic [31:0] out_data;
  logic [15:0] stall_cnt;

  logic        s_in_ready;
  logic        s_out_valid;
  logic [15:0] s_out_ctrl;
  logic [31:0] s_out_data;
  logic [3:0]  s_stall_cnt;

  int total = 0;
  int bad   = 0;

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(16), .BUBBLE_CTRL(BUB), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .stall(stall), .flush(flush),
    .out_ready(out_ready), .out_valid(out_valid), .out_ctrl(out_ctrl),
    .out_data(out_data), .stall_cnt(stall_cnt)
  );

  pipe_stage_reg #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .stall(stall), .flush(flush),
    .out_ready(out_ready), .out_valid(s_out_valid), .out_ctrl(s_out_ctrl),
    .out_data(s_out_data), .stall_cnt(s_stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ctrl_of(input logic [31:0] d);
    return 16'h0100 | d[15:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d);
    in_valid = v;
    in_data  = d;
    in_ctrl  = v ? ctrl_of(d) : 16'h0000;
  endtask

  task automatic test_reset();
    rst = 1'b1; drive(1'b0, 0); stall = 0; flush = 0; out_ready = 1;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", in_ready); end
    total++; if (out_ctrl !== BUB) begin bad++; $display("FAIL reset_ctrl got=%h want=%h", out_ctrl, BUB); end
    total++; if (out_data !== 32'd0 || stall_cnt !== 16'd0) begin
      bad++; $display("FAIL reset_data_cnt got=%h/%0d want=0/0", out_data, stall_cnt);
    end
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_stream();
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 32'(i));
      tick();
      total++; if (out_valid !== 1'b1 || out_data !== 32'(i)) begin
        bad++; $display("FAIL stream_out i=%0d got=%b/%0d want=1/%0d", i, out_valid, out_data, i);
      end
      total++; if (out_ctrl !== ctrl_of(32'(i)) || in_ready !== 1'b1) begin
        bad++; $display("FAIL stream_ctrl_ready i=%0d got=%h/%b want=%h/1", i, out_ctrl, in_ready, ctrl_of(32'(i)));
      end
    end
    drive(1'b0, 0);
    tick();
    total++; if (out_valid !== 1'b0 || out_ctrl !== BUB) begin
      bad++; $display("FAIL stream_drain got=%b/%h want=0/%h", out_valid, out_ctrl, BUB);
    end
    total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL stream_cnt got=%0d want=0", stall_cnt); end
  endtask

  task automatic test_backpressure();
    drive(1'b1, 5);
    tick();
    stall = 1; drive(1'b1, 6);
    tick();
    total++; if (out_data !== 32'd5 || in_ready !== 1'b0) begin
      bad++; $display("FAIL bp_hold got=%0d/%b want=5/0", out_data, in_ready);
    end
    total++; if (stall_cnt !== 16'd1) begin bad++; $display("FAIL bp_cnt1 got=%0d want=1", stall_cnt); end
    drive(1'b0, 0);
    tick();
    total++; if (out_data !== 32'd5 || stall_cnt !== 16'd2) begin
      bad++; $display("FAIL bp_hold2 got=%0d/%0d want=5/2", out_data, stall_cnt);
    end
    stall = 0;
    tick();
    total++; if (out_valid !== 1'b1 || out_data !== 32'd6 || in_ready !== 1'b1) begin
      bad++; $display("FAIL bp_skid_out got=%b/%0d/%b want=1/6/1", out_valid, out_data, in_ready);
    end
    tick();
    total++; if (out_valid !== 1'b0 || stall_cnt !== 16'd2) begin
      bad++; $display("FAIL bp_drain got=%b/%0d want=0/2", out_valid, stall_cnt);
    end
  endtask

  task automatic test_flush();
    drive(1'b1, 7);
    tick();
    stall = 1; drive(1'b1, 8);
    tick();
    drive(1'b1, 9); flush = 1;
    tick();
    flush = 0; stall = 0;
    total++; if (out_valid !== 1'b0 || out_ctrl !== BUB || in_ready !== 1'b1) begin
      bad++; $display("FAIL flush_full got=%b/%h/%b want=0/%h/1", out_valid, out_ctrl, in_ready, BUB);
    end
    total++; if (out_data !== 32'd0 || stall_cnt !== 16'd3) begin
      bad++; $display("FAIL flush_data_cnt got=%0d/%0d want=0/3", out_data, stall_cnt);
    end
    drive(1'b0, 0);
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_ghost got=%b/%0d want=0", out_valid, out_data); end
    // Flush with an input transfer actually accepted the same cycle.
    drive(1'b1, 7);
    tick();
    drive(1'b1, 9); flush = 1;
    tick();
    flush = 0; drive(1'b0, 0);
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL flush_drop got=%b/%b want=0/1", out_valid, in_ready);
    end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_drop2 got=%b/%0d want=0", out_valid, out_data); end
  endtask

  task automatic test_skid_handoff();
    drive(1'b1, 10);
    tick();
    stall = 1; drive(1'b1, 11);
    tick();
    stall = 0; drive(1'b1, 12);
    tick();
    total++; if (out_data !== 32'd11 || in_ready !== 1'b1) begin
      bad++; $display("FAIL hand_main got=%0d/%b want=11/1", out_data, in_ready);
    end
    tick();
    total++; if (out_valid !== 1'b1 || out_data !== 32'd12) begin
      bad++; $display("FAIL hand_next got=%b/%0d want=1/12", out_valid, out_data);
    end
    drive(1'b0, 0);
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL hand_drain got=%b want=0", out_valid); end
  endtask

  task automatic test_out_ready();
    drive(1'b1, 13);
    tick();
    out_ready = 0; drive(1'b1, 14);
    tick();
    drive(1'b1, 15);
    tick();
    total++; if (out_data !== 32'd13 || in_ready !== 1'b0) begin
      bad++; $display("FAIL ordy_hold got=%0d/%b want=13/0", out_data, in_ready);
    end
    out_ready = 1;
    tick();
    total++; if (out_data !== 32'd14) begin bad++; $display("FAIL ordy_second got=%0d want=14", out_data); end
    tick();
    drive(1'b0, 0);
    total++; if (out_valid !== 1'b1 || out_data !== 32'd15) begin
      bad++; $display("FAIL ordy_third got=%b/%0d want=1/15", out_valid, out_data);
    end
    tick();
  endtask

  task automatic test_async_reset();
    drive(1'b1, 20);
    tick();
    stall = 1; drive(1'b1, 21);
    tick();
    #2 rst = 1;
    #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_ctrl !== BUB) begin
      bad++; $display("FAIL areset_now got=%b/%b/%h want=0/1/%h", out_valid, in_ready, out_ctrl, BUB);
    end
    total++; if (out_data !== 32'd0 || stall_cnt !== 16'd0 || s_stall_cnt !== 4'd0) begin
      bad++; $display("FAIL areset_regs got=%0d/%0d/%0d want=0/0/0", out_data, stall_cnt, s_stall_cnt);
    end
    stall = 0; drive(1'b1, 99);
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL areset_ignore got=%b want=0", out_valid); end
    #2 rst = 0; drive(1'b1, 22);
    tick();
    total++; if (out_valid !== 1'b1 || out_data !== 32'd22) begin
      bad++; $display("FAIL areset_first got=%b/%0d want=1/22", out_valid, out_data);
    end
    drive(1'b1, 23);
    tick();
    total++; if (out_data !== 32'd23) begin bad++; $display("FAIL areset_second got=%0d want=23", out_data); end
    drive(1'b0, 0);
    tick();
  endtask

  task automatic test_saturation();
    rst = 1;
    tick();
    rst = 0;
    drive(1'b1, 30);
    tick();
    drive(1'b0, 0); stall = 1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 14) begin
        total++; if (s_stall_cnt !== 4'd14) begin bad++; $display("FAIL sat_14 got=%0d want=14", s_stall_cnt); end
      end
      if (k == 15 || k == 20) begin
        total++; if (s_stall_cnt !== 4'd15) begin bad++; $display("FAIL sat_k%0d got=%0d want=15", k, s_stall_cnt); end
      end
    end
    total++; if (stall_cnt !== 16'd20 || s_out_data !== 32'd30) begin
      bad++; $display("FAIL sat_wide got=%0d/%0d want=20/30", stall_cnt, s_out_data);
    end
    stall = 0;
    tick();
    total++; if (s_out_valid !== 1'b0 || s_stall_cnt !== 4'd15) begin
      bad++; $display("FAIL sat_release got=%b/%0d want=0/15", s_out_valid, s_stall_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_skid_handoff();
    test_out_ready();
    test_async_reset();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
